seg7_scan_capture: RTL and testbench

Receive side of the team's active-low seven-segment display path. The block samples a time-multiplexed segment/anode bus, waits for each digit's pattern to settle, and decodes each pattern back to its 4-bit hex value. It assembles one word per complete scan frame and presents it with a single-cycle valid pulse. It is used on the bench and in loop-back builds to check the display drivers by reading their pins.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 42 ++++
 rtl/seg7_scan_capture.sv | 195 +++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the active-low seven-segment display path.
// The display driver and this capture block both use this table, so the
// pattern map exists in exactly one place.
// Optional feature macro: SEG7_BLANK_EN (see seg7_decode / seg7_scan_capture).
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_PAT_0 = 7'h40;
    localparam logic [6:0] SEG7_PAT_1 = 7'h79;
    localparam logic [6:0] SEG7_PAT_2 = 7'h24;
    localparam logic [6:0] SEG7_PAT_3 = 7'h30;
    localparam logic [6:0] SEG7_PAT_4 = 7'h19;
    localparam logic [6:0] SEG7_PAT_5 = 7'h12;
    localparam logic [6:0] SEG7_PAT_6 = 7'h02;
    localparam logic [6:0] SEG7_PAT_7 = 7'h78;
    localparam logic [6:0] SEG7_PAT_8 = 7'h00;
    localparam logic [6:0] SEG7_PAT_9 = 7'h18;
    localparam logic [6:0] SEG7_PAT_A = 7'h08;
    localparam logic [6:0] SEG7_PAT_B = 7'h03;
    localparam logic [6:0] SEG7_PAT_C = 7'h46;
    localparam logic [6:0] SEG7_PAT_D = 7'h21;
    localparam logic [6:0] SEG7_PAT_E = 7'h06;
    localparam logic [6:0] SEG7_PAT_F = 7'h0E;

    // All segments off
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Frame assembly states of the capture block
    typedef enum logic [1:0] {
        ST_HUNT,
        ST_COLLECT,
        ST_EMIT
    } seg7_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the display driver's pattern table.
// With SEG7_BLANK_EN defined the all-off pattern is accepted as a legal
// blank digit (nibble 0, is_blank high); otherwise it is illegal.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       is_blank
);

    // Map a segment pattern back to its hex value and flag anything unknown
    always_comb begin
        nibble   = 4'h0;
        legal    = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG7_PAT_0: nibble = 4'h0;
            SEG7_PAT_1: nibble = 4'h1;
            SEG7_PAT_2: nibble = 4'h2;
            SEG7_PAT_3: nibble = 4'h3;
            SEG7_PAT_4: nibble = 4'h4;
            SEG7_PAT_5: nibble = 4'h5;
            SEG7_PAT_6: nibble = 4'h6;
            SEG7_PAT_7: nibble = 4'h7;
            SEG7_PAT_8: nibble = 4'h8;
            SEG7_PAT_9: nibble = 4'h9;
            SEG7_PAT_A: nibble = 4'hA;
            SEG7_PAT_B: nibble = 4'hB;
            SEG7_PAT_C: nibble = 4'hC;
            SEG7_PAT_D: nibble = 4'hD;
            SEG7_PAT_E: nibble = 4'hE;
            SEG7_PAT_F: nibble = 4'hF;
`ifdef SEG7_BLANK_EN
            SEG7_BLANK: is_blank = 1'b1;
`endif
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reads a multiplexed active-low seven-segment bus back into a hex word.
// Each digit must hold steady for STABLE_CYCLES samples before it is taken;
// a word is emitted only once every digit of one scan frame has been seen,
// starting from digit 0. Blank-digit support is enabled by SEG7_BLANK_EN.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  err,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]          seg_s1, seg_s2, seg_p;
    logic [DIGITS-1:0]   an_s1, an_s2, an_p;
    logic [CNT_W-1:0]    cnt;

    logic                changed, idle, sel_one;
    logic [IDX_W-1:0]    sel_idx;
    logic                acc_arm, acc_good, err_event;

    logic [3:0]          dec_nibble;
    logic                dec_legal, dec_blank;

    seg7_state_t         state, next_state;
    logic [DIGITS-1:0]   mask, mask_next;
    logic                load_value;
    logic [4*DIGITS-1:0] shadow, shadow_next;
    logic [DIGITS-1:0]   blank_shadow, blank_shadow_next;

    seg7_decode u_decode (
        .pattern  (seg_s2),
        .nibble   (dec_nibble),
        .legal    (dec_legal),
        .is_blank (dec_blank)
    );

    // Two-flop synchronizers; idle (all ones) is the safe reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    // Previous synchronized sample, used to detect any change on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p <= '1;
            an_p  <= '1;
        end else begin
            seg_p <= seg_s2;
            an_p  <= an_s2;
        end
    end

    // Classify the anode bus and find which digit is selected
    always_comb begin
        changed = (seg_s2 != seg_p) || (an_s2 != an_p);
        idle    = &an_s2;
        sel_one = ($countones(~an_s2) == 1);
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s2[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Stability counter: restarts on any change or idle, saturates so a
    // steady digit is taken only once per run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed || idle) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Acceptance fires on the cycle the counter steps onto its limit
    always_comb begin
        acc_arm   = !changed && !idle && (cnt == CNT_ARM);
        acc_good  = acc_arm && sel_one && dec_legal;
        err_event = acc_arm && (!sel_one || !dec_legal);
    end

    // Shadow slots take every good acceptance; only full frames reach value
    always_comb begin
        shadow_next       = shadow;
        blank_shadow_next = blank_shadow;
        if (acc_good) begin
            shadow_next[{sel_idx, 2'b00} +: 4] = dec_nibble;
            blank_shadow_next[sel_idx]         = dec_blank;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and frame mask logic
    always_comb begin
        next_state = state;
        mask_next  = mask;
        load_value = 1'b0;
        case (state)
            ST_HUNT: begin
                if (err_event) begin
                    mask_next = '0;
                end else if (acc_good && (sel_idx == '0)) begin
                    mask_next  = DIGITS'(1);
                    next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (err_event) begin
                    mask_next  = '0;
                    next_state = ST_HUNT;
                end else if (acc_good) begin
                    if (sel_idx == '0) begin
                        mask_next = DIGITS'(1);
                    end else begin
                        mask_next[sel_idx] = 1'b1;
                        if (&mask_next) begin
                            load_value = 1'b1;
                            next_state = ST_EMIT;
                        end
                    end
                end
            end
            ST_EMIT: begin
                mask_next  = '0;
                next_state = ST_HUNT;
            end
            default: begin
                mask_next  = '0;
                next_state = ST_HUNT;
            end
        endcase
    end

    // Frame datapath: mask, shadow slots, published word and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask         <= '0;
            shadow       <= '0;
            blank_shadow <= '0;
            value        <= '0;
            blank        <= '0;
            err          <= 1'b0;
        end else begin
            mask         <= mask_next;
            shadow       <= shadow_next;
            blank_shadow <= blank_shadow_next;
            err          <= err_event;
            if (load_value) begin
                value <= shadow_next;
                blank <= blank_shadow_next;
            end
        end
    end

    // FSM outputs: the valid pulse is the EMIT state itself
    always_comb begin
        value_valid = (state == ST_EMIT);
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture (DIGITS=4, STABLE_CYCLES=8).
// A frame-level model predicts each value_valid / err event when a digit is
// shown; a monitor pops and compares whenever the DUT reports an event.
module tb_seg7_scan_capture;

    localparam int DIGITS        = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LONG_MIN      = STABLE_CYCLES + 4;
    localparam int SHORT_MAX     = STABLE_CYCLES - 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic        value_valid;
    logic        err;
    logic [3:0]  blank;

    typedef struct {
        bit          is_err;
        logic [15:0] value;
        logic [3:0]  blank;
    } event_t;

    event_t      sb[$];
    event_t      ev_exp;
    int          checkCount = 0;
    int          passCount  = 0;

    logic [6:0]  patTab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    bit          mCollecting;
    logic [3:0]  mMask;
    logic [3:0]  mSlots[4];
    logic [3:0]  mBlankSlots;
    logic [15:0] mValue;
    logic [3:0]  mBlank;

    always #5 clk = ~clk;

    seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .blank       (blank)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    function automatic bit decodePattern(input logic [6:0] pat, output logic [3:0] nib, output bit isBlank);
        nib     = 4'h0;
        isBlank = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (patTab[n] == pat) begin
                nib = 4'(n);
                return 1'b1;
            end
        end
`ifdef SEG7_BLANK_EN
        if (pat == 7'h7F) begin
            isBlank = 1'b1;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic modelReset();
        mCollecting = 1'b0;
        mMask       = 4'h0;
        mBlankSlots = 4'h0;
        mValue      = 16'h0;
        mBlank      = 4'h0;
    endtask

    task automatic modelError();
        event_t ev;
        ev.is_err = 1'b1;
        ev.value  = mValue;
        ev.blank  = mBlank;
        sb.push_back(ev);
        mCollecting = 1'b0;
        mMask       = 4'h0;
    endtask

    task automatic modelAccept(input int k, input logic [6:0] pat);
        logic [3:0] nib;
        bit         bl;
        event_t     ev;
        if (!decodePattern(pat, nib, bl)) begin
            modelError();
            return;
        end
        if (k == 0) begin
            mCollecting    = 1'b1;
            mMask          = 4'b0001;
            mSlots[0]      = nib;
            mBlankSlots[0] = bl;
        end else if (mCollecting) begin
            mMask[k]       = 1'b1;
            mSlots[k]      = nib;
            mBlankSlots[k] = bl;
            if (mMask == 4'hF) begin
                mValue      = {mSlots[3], mSlots[2], mSlots[1], mSlots[0]};
                mBlank      = mBlankSlots;
                ev.is_err   = 1'b0;
                ev.value    = mValue;
                ev.blank    = mBlank;
                sb.push_back(ev);
                mCollecting = 1'b0;
                mMask       = 4'h0;
            end
        end
    endtask

    // Called at a negedge; drives one anode/segment pair for hold cycles then idles
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] pat, input int hold, input int gap);
        int lows;
        lows = $countones(~an);
        if (hold >= LONG_MIN) begin
            if (lows == 1) begin
                for (int k = 0; k < 4; k++) if (!an[k]) modelAccept(k, pat);
            end else if (lows > 1) begin
                modelError();
            end
        end
        an_in  = an;
        seg_in = pat;
        repeat (hold) @(negedge clk);
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (gap) @(negedge clk);
    endtask

    task automatic showDigit(input int k, input logic [6:0] pat, input int hold);
        logic [3:0] an;
        an    = 4'hF;
        an[k] = 1'b0;
        applyStimulus(an, pat, hold, 2);
    endtask

    task automatic scanFrame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        showDigit(0, p0, 20);
        showDigit(1, p1, 20);
        showDigit(2, p2, 20);
        showDigit(3, p3, 20);
    endtask

    // Monitor: every reported event must match the oldest predicted one
    always @(negedge clk) begin
        if (rst_n && (value_valid || err)) begin
            if (sb.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_event: got valid=%0b err=%0b value=%h expected no event at %0t",
                         value_valid, err, value, $time);
            end else begin
                ev_exp = sb.pop_front();
                checkOutput("event_err", {31'b0, err}, {31'b0, ev_exp.is_err});
                checkOutput("event_valid", {31'b0, value_valid}, {31'b0, !ev_exp.is_err});
                checkOutput("event_value", {16'b0, value}, {16'b0, ev_exp.value});
                checkOutput("event_blank", {28'b0, blank}, {28'b0, ev_exp.blank});
            end
        end
    end

    initial begin
        logic [3:0] an;
        logic [6:0] pat;
        int         r, hold, gap, i0;

        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_value", {16'b0, value}, 32'h0);
        checkOutput("reset_valid", {31'b0, value_valid}, 32'h0);
        checkOutput("reset_err", {31'b0, err}, 32'h0);
        checkOutput("reset_blank", {28'b0, blank}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain frame 3,2,1,0
        scanFrame(7'h30, 7'h24, 7'h79, 7'h40);
        // Short digit ignored, then F,E,d,C
        showDigit(0, 7'h0E, 6);
        scanFrame(7'h0E, 7'h06, 7'h21, 7'h46);
        // Illegal pattern on digit 2, then a good frame
        showDigit(0, 7'h40, 20);
        showDigit(1, 7'h79, 20);
        showDigit(2, 7'h7E, 20);
        scanFrame(7'h19, 7'h12, 7'h02, 7'h78);
        // Two anodes low
        applyStimulus(4'b1100, 7'h40, 12, 2);
        // Missing digit 3, frame restarts on next digit 0
        showDigit(0, 7'h40, 20);
        showDigit(1, 7'h79, 20);
        showDigit(2, 7'h24, 20);
        scanFrame(7'h18, 7'h00, 7'h78, 7'h02);
        // Blank on digit 3
        scanFrame(7'h40, 7'h40, 7'h40, 7'h7F);
        scanFrame(7'h79, 7'h24, 7'h30, 7'h19);

        // Reset mid-frame after digit 1 accepted
        showDigit(0, 7'h12, 20);
        showDigit(1, 7'h02, 20);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_value", {16'b0, value}, 32'h0);
        checkOutput("midreset_valid", {31'b0, value_valid}, 32'h0);
        checkOutput("midreset_err", {31'b0, err}, 32'h0);
        checkOutput("midreset_blank", {28'b0, blank}, 32'h0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        showDigit(2, 7'h78, 20);
        showDigit(3, 7'h00, 20);
        scanFrame(7'h08, 7'h03, 7'h46, 7'h21);

        // Randomized scans with short, illegal, skipped and faulted digits
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++) begin
                r    = $urandom_range(0, 99);
                gap  = $urandom_range(1, 3);
                hold = $urandom_range(LONG_MIN, LONG_MIN + 10);
                pat  = patTab[$urandom_range(0, 15)];
                if (r < 12) begin
                    pat = 7'($urandom_range(0, 127));
                end else if (r < 20) begin
                    hold = $urandom_range(2, SHORT_MAX);
                end
                if (r >= 20 && r < 25) begin
                    continue;
                end
                if (r >= 96) begin
                    i0 = $urandom_range(0, 3);
                    an = 4'hF;
                    an[i0] = 1'b0;
                    an[(i0 + 1 + $urandom_range(0, 2)) % 4] = 1'b0;
                    applyStimulus(an, pat, hold, gap);
                end else begin
                    an = 4'hF;
                    an[k] = 1'b0;
                    applyStimulus(an, pat, hold, gap);
                end
            end
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 32'h0);
        repeat (20) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
